// File: rtl/bp_fe_bht_update_queue_pkg.sv
// rtl/bp_fe_bht_update_queue_pkg.sv - update record type macro and saturating helper for the BHT update queue
// The BP_FE_BHT_UPDQ_PERF_EN option is documented with the top module.
`ifndef BP_FE_BHT_UPDATE_QUEUE_PKG_SV
`define BP_FE_BHT_UPDATE_QUEUE_PKG_SV

// The index width is a module parameter, so the record is declared through a macro.
`define BP_FE_DECLARE_BHT_UPDATE_S(idx_width_mp) \
    typedef struct packed { \
        logic [idx_width_mp-1:0] idx; \
        logic                    taken; \
    } bp_fe_bht_update_s

package bp_fe_bht_update_queue_pkg;

    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

endpackage

`endif

// File: rtl/bp_fe_bht_update_queue_mem.sv
// rtl/bp_fe_bht_update_queue_mem.sv - unreset flop array, one write port and one combinational read port
module bp_fe_bht_update_queue_mem #(
    parameter int els_p        = 4,
    parameter int width_p      = 10,
    parameter int addr_width_p = $clog2(els_p)
) (
    input  logic                    clk_i,
    input  logic                    w_v_i,
    input  logic [addr_width_p-1:0] w_addr_i,
    input  logic [width_p-1:0]      w_data_i,
    input  logic [addr_width_p-1:0] r_addr_i,
    output logic [width_p-1:0]      r_data_o
);

    logic [width_p-1:0] r_mem [els_p];

    always_ff @(posedge clk_i) begin
        if (w_v_i) begin
            r_mem[w_addr_i] <= w_data_i;
        end
    end

    assign r_data_o = r_mem[r_addr_i];

endmodule

// File: rtl/bp_fe_bht_update_queue.sv
// rtl/bp_fe_bht_update_queue.sv - FIFO of branch-resolution updates draining one per cycle into the BHT write port
// Defining BP_FE_BHT_UPDQ_PERF_EN adds saturating full-stall and flush-drop counters.
module bp_fe_bht_update_queue
    import bp_fe_bht_update_queue_pkg::*;
#(
    parameter int bht_idx_width_p = 9,
    parameter int els_p           = 4
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       upd_v_i,
    input  logic [bht_idx_width_p-1:0] upd_idx_i,
    input  logic                       upd_taken_i,
    output logic                       upd_ready_o,
    input  logic                       flush_i,
    input  logic                       hold_i,
    output logic                       w_v_o,
    output logic [bht_idx_width_p-1:0] idx_w_o,
    output logic                       correct_o,
`ifdef BP_FE_BHT_UPDQ_PERF_EN
    output logic                       empty_o,
    output logic [31:0]                perf_full_cyc_o,
    output logic [31:0]                perf_flush_drop_o
`else
    output logic                       empty_o
`endif
);

    localparam int ptr_width_lp = $clog2(els_p);
    localparam int cnt_width_lp = $clog2(els_p + 1);

    `BP_FE_DECLARE_BHT_UPDATE_S(bht_idx_width_p);

    logic [ptr_width_lp-1:0] r_head;
    logic [ptr_width_lp-1:0] r_tail;
    logic [cnt_width_lp-1:0] r_count;

    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    bp_fe_bht_update_s  w_wr_entry;
    bp_fe_bht_update_s  w_rd_entry;

    assign w_full  = (r_count == cnt_width_lp'(els_p));
    assign w_empty = (r_count == '0);

    // Readiness ignores a same-cycle pop so there is no comb path from the drain side to the push side.
    assign upd_ready_o = ~w_full & ~reset_i;
    assign w_push      = upd_v_i & upd_ready_o & ~flush_i;
    assign w_v_o       = ~w_empty & ~hold_i & ~flush_i;
    assign w_pop       = w_v_o;
    assign empty_o     = w_empty;

    assign w_wr_entry.idx   = upd_idx_i;
    assign w_wr_entry.taken = upd_taken_i;
    assign idx_w_o          = w_rd_entry.idx;
    assign correct_o        = w_rd_entry.taken;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    bp_fe_bht_update_queue_mem #(
        .els_p        (els_p),
        .width_p      ($bits(bp_fe_bht_update_s)),
        .addr_width_p (ptr_width_lp)
    ) u_mem (
        .clk_i    (clk_i),
        .w_v_i    (w_push),
        .w_addr_i (r_tail),
        .w_data_i (w_wr_entry),
        .r_addr_i (r_head),
        .r_data_o (w_rd_entry)
    );

`ifdef BP_FE_BHT_UPDQ_PERF_EN
    logic [31:0] r_perf_full_cyc;
    logic [31:0] r_perf_flush_drop;
    logic [31:0] w_flush_drop_amt;

    // A flush discards everything queued plus the push it suppresses.
    assign w_flush_drop_amt = 32'(r_count) + 32'(upd_v_i & upd_ready_o);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_perf_full_cyc   <= '0;
            r_perf_flush_drop <= '0;
        end else begin
            if (w_full & upd_v_i) begin
                r_perf_full_cyc <= sat_add32(r_perf_full_cyc, 32'd1);
            end
            if (flush_i) begin
                r_perf_flush_drop <= sat_add32(r_perf_flush_drop, w_flush_drop_amt);
            end
        end
    end

    assign perf_full_cyc_o   = r_perf_full_cyc;
    assign perf_flush_drop_o = r_perf_flush_drop;
`endif

endmodule

// File: tb/tb_bp_fe_bht_update_queue.sv
// tb/tb_bp_fe_bht_update_queue.sv - directed vector bench for bp_fe_bht_update_queue
module tb_bp_fe_bht_update_queue;

    localparam int W = 9;

    logic         clk_i       = 1'b0;
    logic         reset_i     = 1'b1;
    logic         upd_v_i     = 1'b0;
    logic [W-1:0] upd_idx_i   = '0;
    logic         upd_taken_i = 1'b0;
    logic         flush_i     = 1'b0;
    logic         hold_i      = 1'b0;
    logic         upd_ready_o;
    logic         w_v_o;
    logic [W-1:0] idx_w_o;
    logic         correct_o;
    logic         empty_o;
`ifdef BP_FE_BHT_UPDQ_PERF_EN
    logic [31:0]  perf_full_cyc_o;
    logic [31:0]  perf_flush_drop_o;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    bp_fe_bht_update_queue #(
        .bht_idx_width_p (W),
        .els_p           (4)
    ) dut (
        .clk_i             (clk_i),
        .reset_i           (reset_i),
        .upd_v_i           (upd_v_i),
        .upd_idx_i         (upd_idx_i),
        .upd_taken_i       (upd_taken_i),
        .upd_ready_o       (upd_ready_o),
        .flush_i           (flush_i),
        .hold_i            (hold_i),
        .w_v_o             (w_v_o),
        .idx_w_o           (idx_w_o),
        .correct_o         (correct_o),
`ifdef BP_FE_BHT_UPDQ_PERF_EN
        .empty_o           (empty_o),
        .perf_full_cyc_o   (perf_full_cyc_o),
        .perf_flush_drop_o (perf_flush_drop_o)
`else
        .empty_o           (empty_o)
`endif
    );

    typedef struct {
        logic         v;
        logic [W-1:0] idx;
        logic         tk;
        logic         fl;
        logic         hd;
        logic         e_rdy;
        logic         e_wv;
        logic [W-1:0] e_idx;
        logic         e_cor;
        logic         e_emp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic v, input logic [W-1:0] idx, input logic tk,
                                input logic fl, input logic hd, input logic e_rdy,
                                input logic e_wv, input logic [W-1:0] e_idx,
                                input logic e_cor, input logic e_emp);
        vec_t t;
        t.v = v; t.idx = idx; t.tk = tk; t.fl = fl; t.hd = hd;
        t.e_rdy = e_rdy; t.e_wv = e_wv; t.e_idx = e_idx; t.e_cor = e_cor; t.e_emp = e_emp;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t t, input string tag);
        @(negedge clk_i);
        upd_v_i     = t.v;
        upd_idx_i   = t.idx;
        upd_taken_i = t.tk;
        flush_i     = t.fl;
        hold_i      = t.hd;
        #1;
        chk({tag, "_ready"}, 32'(upd_ready_o), 32'(t.e_rdy));
        chk({tag, "_wv"},    32'(w_v_o),       32'(t.e_wv));
        chk({tag, "_empty"}, 32'(empty_o),     32'(t.e_emp));
        if (t.e_wv) begin
            chk({tag, "_idx"},     32'(idx_w_o),   32'(t.e_idx));
            chk({tag, "_correct"}, 32'(correct_o), 32'(t.e_cor));
        end
    endtask

    initial begin
        // basic push then drain
        vecs.push_back(mk(0, 9'h000, 0, 0, 0, 1, 0, 9'h000, 0, 1));
        vecs.push_back(mk(1, 9'h005, 1, 0, 0, 1, 0, 9'h000, 0, 1));
        vecs.push_back(mk(0, 9'h000, 0, 0, 0, 1, 1, 9'h005, 1, 0));
        vecs.push_back(mk(0, 9'h000, 0, 0, 0, 1, 0, 9'h000, 0, 1));
        // hold while filling, fifth push refused, ordered drain
        vecs.push_back(mk(1, 9'h001, 0, 0, 1, 1, 0, 9'h000, 0, 1));
        vecs.push_back(mk(1, 9'h002, 1, 0, 1, 1, 0, 9'h000, 0, 0));
        vecs.push_back(mk(1, 9'h003, 0, 0, 1, 1, 0, 9'h000, 0, 0));
        vecs.push_back(mk(1, 9'h004, 1, 0, 1, 1, 0, 9'h000, 0, 0));
        vecs.push_back(mk(1, 9'h005, 1, 0, 1, 0, 0, 9'h000, 0, 0));
        vecs.push_back(mk(0, 9'h000, 0, 0, 0, 0, 1, 9'h001, 0, 0));
        vecs.push_back(mk(0, 9'h000, 0, 0, 0, 1, 1, 9'h002, 1, 0));
        vecs.push_back(mk(0, 9'h000, 0, 0, 0, 1, 1, 9'h003, 0, 0));
        vecs.push_back(mk(0, 9'h000, 0, 0, 0, 1, 1, 9'h004, 1, 0));
        vecs.push_back(mk(0, 9'h000, 0, 0, 0, 1, 0, 9'h000, 0, 1));
        // full with simultaneous push attempt and pop
        vecs.push_back(mk(1, 9'h010, 1, 0, 1, 1, 0, 9'h000, 0, 1));
        vecs.push_back(mk(1, 9'h011, 0, 0, 1, 1, 0, 9'h000, 0, 0));
        vecs.push_back(mk(1, 9'h012, 1, 0, 1, 1, 0, 9'h000, 0, 0));
        vecs.push_back(mk(1, 9'h013, 0, 0, 1, 1, 0, 9'h000, 0, 0));
        vecs.push_back(mk(1, 9'h01F, 1, 0, 0, 0, 1, 9'h010, 1, 0));
        vecs.push_back(mk(0, 9'h000, 0, 0, 0, 1, 1, 9'h011, 0, 0));
        vecs.push_back(mk(0, 9'h000, 0, 0, 0, 1, 1, 9'h012, 1, 0));
        vecs.push_back(mk(0, 9'h000, 0, 0, 0, 1, 1, 9'h013, 0, 0));
        vecs.push_back(mk(0, 9'h000, 0, 0, 0, 1, 0, 9'h000, 0, 1));
        // flush with a concurrent push
        vecs.push_back(mk(1, 9'h020, 1, 0, 1, 1, 0, 9'h000, 0, 1));
        vecs.push_back(mk(1, 9'h021, 0, 0, 1, 1, 0, 9'h000, 0, 0));
        vecs.push_back(mk(1, 9'h022, 1, 0, 1, 1, 0, 9'h000, 0, 0));
        vecs.push_back(mk(1, 9'h023, 1, 1, 0, 1, 0, 9'h000, 0, 0));
        vecs.push_back(mk(0, 9'h000, 0, 0, 0, 1, 0, 9'h000, 0, 1));
        vecs.push_back(mk(1, 9'h124, 0, 0, 0, 1, 0, 9'h000, 0, 1));
        vecs.push_back(mk(0, 9'h000, 0, 0, 0, 1, 1, 9'h124, 0, 0));
        vecs.push_back(mk(0, 9'h000, 0, 0, 0, 1, 0, 9'h000, 0, 1));

        #1;
        chk("reset_wv",    32'(w_v_o),       32'd0);
        chk("reset_empty", 32'(empty_o),     32'd1);
        chk("reset_ready", 32'(upd_ready_o), 32'd0);
        @(negedge clk_i);
        reset_i = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], $sformatf("v%0d", i));
        end

        // asynchronous reset during a drain
        apply(mk(1, 9'h030, 1, 0, 1, 1, 0, 9'h000, 0, 1), "rst_a");
        apply(mk(1, 9'h031, 0, 0, 1, 1, 0, 9'h000, 0, 0), "rst_b");
        apply(mk(0, 9'h000, 0, 0, 0, 1, 1, 9'h030, 1, 0), "rst_c");
        reset_i = 1'b1;
        #1;
        chk("rst_async_wv",    32'(w_v_o),       32'd0);
        chk("rst_async_ready", 32'(upd_ready_o), 32'd0);
        chk("rst_async_empty", 32'(empty_o),     32'd1);
        @(negedge clk_i);
        reset_i = 1'b0;
        #1;
        chk("rst_rel_empty", 32'(empty_o),     32'd1);
        chk("rst_rel_wv",    32'(w_v_o),       32'd0);
        chk("rst_rel_ready", 32'(upd_ready_o), 32'd1);
        apply(mk(0, 9'h000, 0, 0, 0, 1, 0, 9'h000, 0, 1), "rst_d");

`ifdef BP_FE_BHT_UPDQ_PERF_EN
        chk("perf_full_reset", perf_full_cyc_o,   32'd0);
        chk("perf_drop_reset", perf_flush_drop_o, 32'd0);
        for (int i = 0; i < 4; i++) begin
            apply(mk(1, W'(9'h040 + i), 1, 0, 1, 1, 0, 9'h000, 0, (i == 0)), $sformatf("pf_fill%0d", i));
        end
        for (int i = 0; i < 10; i++) begin
            apply(mk(1, 9'h0FF, 0, 0, 1, 0, 0, 9'h000, 0, 0), $sformatf("pf_full%0d", i));
        end
        apply(mk(0, 9'h000, 0, 0, 0, 0, 1, 9'h040, 1, 0), "pf_pop");
        apply(mk(0, 9'h000, 0, 1, 0, 1, 0, 9'h000, 0, 0), "pf_flush");
        @(negedge clk_i);
        flush_i = 1'b0;
        hold_i  = 1'b0;
        upd_v_i = 1'b0;
        #1;
        chk("perf_full_cyc",   perf_full_cyc_o,   32'd10);
        chk("perf_flush_drop", perf_flush_drop_o, 32'd3);
        chk("perf_empty",      32'(empty_o),      32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
